// File: rtl/fpu_add_sched_pkg.sv
// rtl/fpu_add_sched_pkg.sv - shared constants and types for the FP add scheduler
package fpu_add_sched_pkg;

    localparam int C_FPU_SCHED_NREQ  = 4;
    localparam int C_FPU_SCHED_LAT   = 3;
    localparam int C_FPU_SCHED_WIDTH = 32;
    localparam int C_FPU_TAG_W       = $clog2(C_FPU_SCHED_NREQ);

    typedef struct packed {
        logic                   valid;
        logic [C_FPU_TAG_W-1:0] tag;
    } fpu_sched_tag_t;

endpackage

// File: rtl/fpu_rr_arb.sv
// rtl/fpu_rr_arb.sv - round-robin arbiter, pointer starts so that index 0 wins first
module fpu_rr_arb
    import fpu_add_sched_pkg::*;
#(
    parameter int NREQ  = C_FPU_SCHED_NREQ,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_advance,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;

    // Scan starts one past the last winner so the last winner has lowest priority.
    always_comb begin
        int c;
        c       = 0;
        w_found = 1'b0;
        o_gnt   = '0;
        o_idx   = '0;
        for (int k = 1; k < NREQ + 1; k++) begin
            c = int'(r_ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            if (!w_found && i_req[c]) begin
                w_found  = 1'b1;
                o_gnt[c] = 1'b1;
                o_idx    = IDX_W'(c);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_ptr <= IDX_W'(NREQ - 1);
        end else if (i_advance) begin
            r_ptr <= o_idx;
        end
    end

endmodule

// File: rtl/fpu_add_sched.sv
// rtl/fpu_add_sched.sv - shares one fixed-latency FP adder among NREQ requesters
module fpu_add_sched
    import fpu_add_sched_pkg::*;
#(
    parameter int NREQ    = C_FPU_SCHED_NREQ,
    parameter int LATENCY = C_FPU_SCHED_LAT,
    parameter int WIDTH   = C_FPU_SCHED_WIDTH,
    parameter int TAG_W   = $clog2(NREQ)
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  Clear_SI,
    input  logic [NREQ-1:0]       Req_valid_SI,
    output logic [NREQ-1:0]       Req_ready_SO,
    input  logic [NREQ*WIDTH-1:0] Req_opA_DI,
    input  logic [NREQ*WIDTH-1:0] Req_opB_DI,
    input  logic [NREQ-1:0]       Req_sub_SI,
    output logic                  Issue_valid_SO,
    output logic [WIDTH-1:0]      Issue_opA_DO,
    output logic [WIDTH-1:0]      Issue_opB_DO,
    output logic [TAG_W-1:0]      Issue_tag_DO,
    input  logic [WIDTH-1:0]      Adder_res_DI,
    output logic [NREQ-1:0]       Res_valid_SO,
    input  logic [NREQ-1:0]       Res_ready_SI,
    output logic [NREQ*WIDTH-1:0] Res_data_DO,
    output logic                  Busy_SO
);

    logic [NREQ-1:0]       r_outstanding;
    logic [NREQ-1:0]       r_res_valid;
    logic [NREQ*WIDTH-1:0] r_res_data;
    logic                  r_issue_valid;
    logic [WIDTH-1:0]      r_issue_opa;
    logic [WIDTH-1:0]      r_issue_opb;
    logic [TAG_W-1:0]      r_issue_tag;
    logic [LATENCY-1:0]    r_pipe_valid;
    logic [TAG_W-1:0]      r_pipe_tag [LATENCY];

    logic [NREQ-1:0]  w_handshake;
    logic [NREQ-1:0]  w_eligible;
    logic [NREQ-1:0]  w_arb_req;
    logic [NREQ-1:0]  w_gnt;
    logic [TAG_W-1:0] w_idx;
    logic             w_accept;
    logic             w_flush;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic             w_wr;
    logic [TAG_W-1:0] w_wtag;

    // A result consumed this cycle frees its requester for a grant in the same cycle.
    assign w_handshake = r_res_valid & Res_ready_SI;
    assign w_eligible  = Req_valid_SI & ~(r_outstanding & ~w_handshake);
    assign w_flush     = !Rst_RBI || Clear_SI;
    assign w_arb_req   = w_flush ? '0 : w_eligible;
    assign w_accept    = |w_gnt;

    fpu_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (TAG_W)
    ) u_arb (
        .i_clk     (Clk_CI),
        .i_rstn    (Rst_RBI),
        .i_req     (w_arb_req),
        .i_advance (w_accept),
        .o_gnt     (w_gnt),
        .o_idx     (w_idx)
    );

    assign w_opa = Req_opA_DI[int'(w_idx)*WIDTH +: WIDTH];
    assign w_opb = Req_sub_SI[w_idx]
                 ? {~Req_opB_DI[int'(w_idx)*WIDTH + WIDTH - 1],
                    Req_opB_DI[int'(w_idx)*WIDTH +: WIDTH-1]}
                 : Req_opB_DI[int'(w_idx)*WIDTH +: WIDTH];

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_issue_valid <= 1'b0;
            r_issue_opa   <= '0;
            r_issue_opb   <= '0;
            r_issue_tag   <= '0;
        end else if (Clear_SI || !w_accept) begin
            r_issue_valid <= 1'b0;
        end else begin
            r_issue_valid <= 1'b1;
            r_issue_opa   <= w_opa;
            r_issue_opb   <= w_opb;
            r_issue_tag   <= w_idx;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (w_flush) begin
            r_pipe_valid <= '0;
        end else begin
            r_pipe_valid[0] <= r_issue_valid;
            for (int k = 1; k < LATENCY; k++) begin
                r_pipe_valid[k] <= r_pipe_valid[k-1];
            end
        end
        r_pipe_tag[0] <= r_issue_tag;
        for (int k = 1; k < LATENCY; k++) begin
            r_pipe_tag[k] <= r_pipe_tag[k-1];
        end
    end

    assign w_wr   = r_pipe_valid[LATENCY-1];
    assign w_wtag = r_pipe_tag[LATENCY-1];

    // One outstanding op per requester means the target buffer is always free at write.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_res_valid <= '0;
            r_res_data  <= '0;
        end else if (Clear_SI) begin
            r_res_valid <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_wr && (w_wtag == TAG_W'(i))) begin
                    r_res_valid[i]                <= 1'b1;
                    r_res_data[i*WIDTH +: WIDTH]  <= Adder_res_DI;
                end else if (w_handshake[i]) begin
                    r_res_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (w_flush) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= (r_outstanding & ~w_handshake) | w_gnt;
        end
    end

    assign Req_ready_SO   = w_gnt;
    assign Issue_valid_SO = r_issue_valid;
    assign Issue_opA_DO   = r_issue_opa;
    assign Issue_opB_DO   = r_issue_opb;
    assign Issue_tag_DO   = r_issue_tag;
    assign Res_valid_SO   = r_res_valid;
    assign Res_data_DO    = r_res_data;
    assign Busy_SO        = |r_outstanding;

endmodule

// File: tb/tb_fpu_add_sched.sv
// tb/tb_fpu_add_sched.sv - self-checking bench for fpu_add_sched
module tb_fpu_add_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int W    = 32;
    localparam int TW   = 2;

    logic                Clk_CI = 1'b0;
    logic                Rst_RBI = 1'b0;
    logic                Clear_SI = 1'b0;
    logic [NREQ-1:0]     Req_valid_SI = '0;
    logic [NREQ-1:0]     Req_ready_SO;
    logic [NREQ*W-1:0]   Req_opA_DI = '0;
    logic [NREQ*W-1:0]   Req_opB_DI = '0;
    logic [NREQ-1:0]     Req_sub_SI = '0;
    logic                Issue_valid_SO;
    logic [W-1:0]        Issue_opA_DO;
    logic [W-1:0]        Issue_opB_DO;
    logic [TW-1:0]       Issue_tag_DO;
    logic [W-1:0]        Adder_res_DI;
    logic [NREQ-1:0]     Res_valid_SO;
    logic [NREQ-1:0]     Res_ready_SI = '0;
    logic [NREQ*W-1:0]   Res_data_DO;
    logic                Busy_SO;

    fpu_add_sched #(.NREQ(NREQ), .LATENCY(LAT), .WIDTH(W)) dut (
        .Clk_CI         (Clk_CI),
        .Rst_RBI        (Rst_RBI),
        .Clear_SI       (Clear_SI),
        .Req_valid_SI   (Req_valid_SI),
        .Req_ready_SO   (Req_ready_SO),
        .Req_opA_DI     (Req_opA_DI),
        .Req_opB_DI     (Req_opB_DI),
        .Req_sub_SI     (Req_sub_SI),
        .Issue_valid_SO (Issue_valid_SO),
        .Issue_opA_DO   (Issue_opA_DO),
        .Issue_opB_DO   (Issue_opB_DO),
        .Issue_tag_DO   (Issue_tag_DO),
        .Adder_res_DI   (Adder_res_DI),
        .Res_valid_SO   (Res_valid_SO),
        .Res_ready_SI   (Res_ready_SI),
        .Res_data_DO    (Res_data_DO),
        .Busy_SO        (Busy_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    function automatic logic [W-1:0] adder_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
    endfunction

    // Stand-in adder: result of whatever was on the issue port LAT cycles earlier.
    logic [W-1:0] hist [LAT];
    always @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            for (int k = 0; k < LAT; k++) hist[k] <= '0;
        end else begin
            hist[0] <= adder_fn(Issue_opA_DO, Issue_opB_DO);
            for (int k = 1; k < LAT; k++) hist[k] <= hist[k-1];
        end
    end
    assign Adder_res_DI = hist[LAT-1];

    typedef struct {
        int           tag;
        int           wc;
        logic [W-1:0] res;
    } fl_t;

    fl_t             q[$];
    int              m_ptr;
    logic [NREQ-1:0] m_out;
    logic [NREQ-1:0] m_rv;
    logic [NREQ*W-1:0] m_rd;
    logic            m_iv;
    logic [W-1:0]    m_ia;
    logic [W-1:0]    m_ib;
    logic [TW-1:0]   m_it;
    int              cyc;
    int              n_chk;
    int              n_err;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ptr = NREQ - 1;
        m_out = '0;
        m_rv  = '0;
        m_rd  = '0;
        m_iv  = 1'b0;
        m_ia  = '0;
        m_ib  = '0;
        m_it  = '0;
        q.delete();
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            Req_opA_DI[i*W +: W] = $urandom;
            Req_opB_DI[i*W +: W] = $urandom;
            Req_sub_SI[i]        = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rdy,
                            input logic clr, input logic rstn);
        logic [NREQ-1:0] busy_out;
        logic [NREQ-1:0] elig;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] h;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        int              gi;
        fl_t             e;
        Req_valid_SI = v;
        Res_ready_SI = rdy;
        Clear_SI     = clr;
        Rst_RBI      = rstn;
        #2;
        g  = '0;
        gi = 0;
        if (rstn && !clr) begin
            busy_out = m_out & ~(m_rv & rdy);
            elig     = v & ~busy_out;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (g == '0 && elig[c]) begin
                    g[c] = 1'b1;
                    gi   = c;
                end
            end
        end
        chk("req_ready",   256'(Req_ready_SO),   256'(g));
        chk("res_valid",   256'(Res_valid_SO),   256'(m_rv));
        chk("busy",        256'(Busy_SO),        256'(|m_out));
        chk("issue_valid", 256'(Issue_valid_SO), 256'(m_iv));
        chk("issue_opA",   256'(Issue_opA_DO),   256'(m_ia));
        chk("issue_opB",   256'(Issue_opB_DO),   256'(m_ib));
        chk("issue_tag",   256'(Issue_tag_DO),   256'(m_it));
        chk("res_data",    256'(Res_data_DO),    256'(m_rd));
        if (!rstn) begin
            m_reset();
        end else if (clr) begin
            m_iv  = 1'b0;
            m_out = '0;
            m_rv  = '0;
            q.delete();
        end else begin
            h = m_rv & rdy;
            if (q.size() > 0 && q[0].wc == cyc) begin
                m_rv[q[0].tag]          = 1'b1;
                m_rd[q[0].tag*W +: W]   = q[0].res;
                void'(q.pop_front());
            end
            m_rv  = m_rv & ~h;
            m_out = (m_out & ~h) | g;
            if (g != '0) begin
                a = Req_opA_DI[gi*W +: W];
                b = Req_opB_DI[gi*W +: W];
                if (Req_sub_SI[gi]) b[W-1] = ~b[W-1];
                m_iv  = 1'b1;
                m_ia  = a;
                m_ib  = b;
                m_it  = TW'(gi);
                e.tag = gi;
                e.wc  = cyc + 1 + LAT;
                e.res = adder_fn(a, b);
                q.push_back(e);
                m_ptr = gi;
            end else begin
                m_iv = 1'b0;
            end
        end
        cyc++;
        @(posedge Clk_CI);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        m_reset();
        Rst_RBI = 1'b0;
        repeat (2) @(posedge Clk_CI);
        #1;
        do_cycle(4'hF, 4'h0, 1'b0, 1'b0);

        // single add on requester 0
        rand_ops();
        Req_opA_DI[31:0] = 32'h3F800000;
        Req_opB_DI[31:0] = 32'h40000000;
        Req_sub_SI[0]    = 1'b0;
        do_cycle(4'b0001, 4'h0, 1'b0, 1'b1);
        chk("t1_issue_valid", 256'(Issue_valid_SO), 256'(1'b1));
        chk("t1_issue_opB",   256'(Issue_opB_DO),   256'(32'h40000000));
        repeat (3) do_cycle(4'h0, 4'h0, 1'b0, 1'b1);
        chk("t1_res_not_yet", 256'(Res_valid_SO), 256'(4'b0000));
        do_cycle(4'h0, 4'h0, 1'b0, 1'b1);
        chk("t1_res_valid", 256'(Res_valid_SO),      256'(4'b0001));
        chk("t1_res_data",  256'(Res_data_DO[31:0]), 256'(32'h40400000));
        do_cycle(4'h0, 4'hF, 1'b0, 1'b1);
        do_cycle(4'h0, 4'hF, 1'b0, 1'b1);

        // all requesters held valid
        repeat (10) begin
            rand_ops();
            do_cycle(4'hF, 4'hF, 1'b0, 1'b1);
        end
        repeat (8) do_cycle(4'h0, 4'hF, 1'b0, 1'b1);

        // subtract on requester 2
        rand_ops();
        Req_opA_DI[2*W +: W] = 32'h40400000;
        Req_opB_DI[2*W +: W] = 32'h3F800000;
        Req_sub_SI[2]        = 1'b1;
        do_cycle(4'b0100, 4'h0, 1'b0, 1'b1);
        chk("t3_issue_opB", 256'(Issue_opB_DO), 256'(32'hBF800000));
        chk("t3_issue_tag", 256'(Issue_tag_DO), 256'(2'd2));
        repeat (4) do_cycle(4'h0, 4'h0, 1'b0, 1'b1);
        chk("t3_res_valid", 256'(Res_valid_SO),          256'(4'b0100));
        chk("t3_res_data",  256'(Res_data_DO[2*W +: W]), 256'(32'h40000000));
        do_cycle(4'h0, 4'b0100, 1'b0, 1'b1);

        // requester 1 back-pressures its result
        repeat (20) begin
            rand_ops();
            do_cycle(4'hF, 4'b1101, 1'b0, 1'b1);
        end
        repeat (8) do_cycle(4'h0, 4'hF, 1'b0, 1'b1);

        // clear with two ops in flight
        rand_ops();
        do_cycle(4'b0001, 4'hF, 1'b0, 1'b1);
        do_cycle(4'b0010, 4'hF, 1'b0, 1'b1);
        do_cycle(4'b1000, 4'hF, 1'b1, 1'b1);
        chk("t5_busy",      256'(Busy_SO),      256'(1'b0));
        chk("t5_res_valid", 256'(Res_valid_SO), 256'(4'b0000));
        repeat (6) do_cycle(4'h0, 4'hF, 1'b0, 1'b1);

        // reset pulse mid-traffic
        repeat (3) begin
            rand_ops();
            do_cycle(4'hF, 4'hF, 1'b0, 1'b1);
        end
        do_cycle(4'hF, 4'hF, 1'b0, 1'b0);
        do_cycle(4'hF, 4'hF, 1'b0, 1'b1);
        repeat (6) do_cycle(4'h0, 4'hF, 1'b0, 1'b1);

        // randomized traffic
        repeat (800) begin
            rand_ops();
            do_cycle(NREQ'($urandom), NREQ'($urandom),
                     ($urandom_range(0, 39) == 0), ($urandom_range(0, 79) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
